// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_pkg
// Description : Shared encodings and opcode-to-target lookup for the
//               instruction dispatcher and its execution FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_START  = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    localparam logic [3:0] FSM_ALU  = 4'h0;
    localparam logic [3:0] FSM_LDI  = 4'h1;
    localparam logic [3:0] FSM_MOV  = 4'h2;
    localparam logic [3:0] FSM_NONE = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int P1_MSB  = 11;
    localparam int P1_LSB  = 6;
    localparam int P2_MSB  = 5;
    localparam int P2_LSB  = 0;

    // FSM_NONE doubles as the "illegal opcode" marker.
    function automatic logic [3:0] opcode_target(input logic [3:0] op);
        logic [3:0] tgt;
        if (op <= 4'h7)
            tgt = FSM_ALU;
        else if (op == 4'h8)
            tgt = FSM_LDI;
        else if (op == 4'h9)
            tgt = FSM_MOV;
        else
            tgt = FSM_NONE;
        return tgt;
    endfunction

    function automatic logic opcode_legal(input logic [3:0] op);
        return opcode_target(op) != FSM_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_timeout_ctr
// Description : Cycle counter that flags the last permitted wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int c_ctr_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_ctr_w-1:0] c_last = c_ctr_w'(TIMEOUT_CYCLES - 1);

    logic [c_ctr_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable)
            r_count <= r_count + 1'b1;
    end

    assign o_expire = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/instr_dispatch_fsm.sv
`default_nettype none
// ============================================================================
// Module      : instr_dispatch_fsm
// Description : Accepts instruction words, starts the matching execution FSM
//               and waits for its done pulse or a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_dispatch_fsm
    import dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_instr_valid,
    input  logic [15:0]      i_instr_data,
    output logic             o_instr_ready,
    output logic [3:0]       o_fsm_start,
    output logic [3:0]       o_opcode,
    output logic [5:0]       o_param1,
    output logic [5:0]       o_param2,
    input  logic             i_done,
    output logic             o_busy,
    output logic             o_retire,
    output logic             o_err_illegal,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_retired_count
);

    logic [1:0]       r_state;
    logic             r_ready;
    logic [3:0]       r_fsm_start;
    logic [3:0]       r_opcode;
    logic [5:0]       r_param1;
    logic [5:0]       r_param2;
    logic             r_busy;
    logic             r_retire;
    logic             r_err_illegal;
    logic             r_err_timeout;
    logic [CNT_W-1:0] r_retired_count;

    logic w_tmo_clear;
    logic w_tmo_enable;
    logic w_tmo_expire;

    assign w_tmo_clear  = (r_state == ST_START);
    assign w_tmo_enable = (r_state == ST_WAIT) && !i_done;

    dispatch_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_expire (w_tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_ready         <= 1'b0;
            r_fsm_start     <= FSM_NONE;
            r_opcode        <= '0;
            r_param1        <= '0;
            r_param2        <= '0;
            r_busy          <= 1'b0;
            r_retire        <= 1'b0;
            r_err_illegal   <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_retired_count <= '0;
        end else begin
            r_retire      <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_fsm_start   <= FSM_NONE;

            case (r_state)
                ST_IDLE: begin
                    // Ready rises one cycle after re-entering IDLE.
                    if (r_ready && i_instr_valid) begin
                        r_opcode <= i_instr_data[OPC_MSB:OPC_LSB];
                        r_param1 <= i_instr_data[P1_MSB:P1_LSB];
                        r_param2 <= i_instr_data[P2_MSB:P2_LSB];
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_DECODE;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (opcode_legal(r_opcode)) begin
                        r_fsm_start <= opcode_target(r_opcode);
                        r_state     <= ST_START;
                    end else begin
                        r_err_illegal <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over an expiring timeout.
                    if (i_done) begin
                        r_retire        <= 1'b1;
                        r_retired_count <= r_retired_count + 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= ST_IDLE;
                    end else if (w_tmo_expire) begin
                        r_err_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_instr_ready   = r_ready;
    assign o_fsm_start     = r_fsm_start;
    assign o_opcode        = r_opcode;
    assign o_param1        = r_param1;
    assign o_param2        = r_param2;
    assign o_busy          = r_busy;
    assign o_retire        = r_retire;
    assign o_err_illegal   = r_err_illegal;
    assign o_err_timeout   = r_err_timeout;
    assign o_retired_count = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_dispatch_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_dispatch_fsm
// Description : Directed and randomized self-checking bench for the dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_dispatch_fsm;

    localparam int TO = 32;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_instr_valid = 1'b0;
    logic [15:0]  i_instr_data = '0;
    logic         i_done = 1'b0;
    logic         o_instr_ready;
    logic [3:0]   o_fsm_start;
    logic [3:0]   o_opcode;
    logic [5:0]   o_param1;
    logic [5:0]   o_param2;
    logic         o_busy;
    logic         o_retire;
    logic         o_err_illegal;
    logic         o_err_timeout;
    logic [W-1:0] o_retired_count;

    int checks    = 0;
    int failures  = 0;
    int cur_c     = 0;
    int exp_count = 0;

    instr_dispatch_fsm #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_instr_valid   (i_instr_valid),
        .i_instr_data    (i_instr_data),
        .o_instr_ready   (o_instr_ready),
        .o_fsm_start     (o_fsm_start),
        .o_opcode        (o_opcode),
        .o_param1        (o_param1),
        .o_param2        (o_param2),
        .i_done          (i_done),
        .o_busy          (o_busy),
        .o_retire        (o_retire),
        .o_err_illegal   (o_err_illegal),
        .o_err_timeout   (o_err_timeout),
        .o_retired_count (o_retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, cur_c, obs, exp);
        end
    endtask

    // Target table: 0-7 ALU, 8 load-imm, 9 move, anything else illegal (-1).
    function automatic int ref_target(input int op);
        if (op < 8)  return 0;
        if (op == 8) return 1;
        if (op == 9) return 2;
        return -1;
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (o_instr_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        cur_c = -1;
        check("ready_before_accept", 32'(o_instr_ready), 32'd1);
    endtask

    // j = WAIT cycle (1-based) in which done is presented; outside 1..TO means never.
    // c counts edges after the accepting edge (c=0); e is the edge that ends the instruction.
    task automatic run_instr(input logic [15:0] word, input int j, input bit done_in_start);
        int         tgt, e;
        bit         legal, retires;
        logic [3:0] op;
        logic [5:0] p1, p2;
        op      = word[15:12];
        p1      = word[11:6];
        p2      = word[5:0];
        tgt     = ref_target(int'(op));
        legal   = (tgt >= 0);
        retires = legal && (j >= 1) && (j <= TO);
        if (!legal)
            e = 1;
        else if (retires)
            e = j + 2;
        else
            e = TO + 2;

        wait_ready();
        for (int c = 0; c <= e + 1; c++) begin
            i_instr_valid = (c <= 2);
            i_instr_data  = (c == 0) ? word : 16'($urandom);
            i_done        = (done_in_start && c == 2) || (retires && c == j + 2);
            @(posedge clk); #1;
            cur_c = c;
            if (retires && c == e)
                exp_count = (exp_count + 1) % (1 << W);
            check("busy",        32'(o_busy),          32'(c < e));
            check("fsm_start",   32'(o_fsm_start),     (legal && c == 1) ? 32'(tgt) : 32'hF);
            check("ready",       32'(o_instr_ready),   32'(c == e + 1));
            check("retire",      32'(o_retire),        32'(retires && c == e));
            check("err_timeout", 32'(o_err_timeout),   32'(legal && !retires && c == e));
            check("err_illegal", 32'(o_err_illegal),   32'(!legal && c == e));
            check("opcode",      32'(o_opcode),        32'(op));
            check("param1",      32'(o_param1),        32'(p1));
            check("param2",      32'(o_param2),        32'(p2));
            check("count",       32'(o_retired_count), 32'(exp_count));
        end
        i_done        = 1'b0;
        i_instr_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] w;

        // Reset state while reset is held
        #12;
        cur_c = -2;
        check("rst_ready",     32'(o_instr_ready),   32'd0);
        check("rst_fsm_start", 32'(o_fsm_start),     32'hF);
        check("rst_busy",      32'(o_busy),          32'd0);
        check("rst_opcode",    32'(o_opcode),        32'd0);
        check("rst_param1",    32'(o_param1),        32'd0);
        check("rst_param2",    32'(o_param2),        32'd0);
        check("rst_pulses",    32'({o_retire, o_err_illegal, o_err_timeout}), 32'd0);
        check("rst_count",     32'(o_retired_count), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(o_instr_ready), 32'd1);

        // Directed cases
        run_instr(16'h1845, 11, 1'b0);
        run_instr(16'hA000, 0, 1'b0);
        run_instr(16'h3ABC, 0, 1'b0);
        run_instr(16'h0123, TO, 1'b0);
        run_instr(16'h8F0F, 3, 1'b1);
        run_instr(16'h9555, 1, 1'b0);
        run_instr(16'hF3C1, 0, 1'b1);

        // Randomized instructions over all opcodes and done timings
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            run_instr(w, int'($urandom_range(1, TO + 2)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset during START
        wait_ready();
        i_instr_valid = 1'b1;
        i_instr_data  = 16'h2040;
        @(posedge clk); #1;
        i_instr_valid = 1'b0;
        @(posedge clk); #1;
        cur_c = -3;
        check("mid_start_code", 32'(o_fsm_start), 32'h0);
        #3 rst_n = 1'b0;
        #1;
        exp_count = 0;
        check("mid_rst_fsm_start", 32'(o_fsm_start),     32'hF);
        check("mid_rst_busy",      32'(o_busy),          32'd0);
        check("mid_rst_count",     32'(o_retired_count), 32'd0);
        check("mid_rst_ready",     32'(o_instr_ready),   32'd0);
        check("mid_rst_opcode",    32'(o_opcode),        32'd0);
        check("mid_rst_pulses",    32'({o_retire, o_err_illegal, o_err_timeout}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_hold_fsm",  32'(o_fsm_start),     32'hF);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready",  32'(o_instr_ready), 32'd1);
        check("post_rst_pulses", 32'({o_retire, o_err_illegal, o_err_timeout}), 32'd0);
        run_instr(16'h9ABC, 5, 1'b0);

        // Quick retires until the counter wraps
        for (int i = 0; i < (1 << W) - 2; i++) begin
            w = {4'($urandom_range(0, 9)), 12'($urandom)};
            run_instr(w, 1, 1'b0);
        end
        cur_c = -4;
        check("pre_wrap_count", 32'(o_retired_count), 32'hFF);
        run_instr(16'h8001, 1, 1'b0);
        cur_c = -5;
        check("wrap_count", 32'(o_retired_count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_dispatch_fsm.md
Name: instr_dispatch_fsm

Overview:
- Initiator side of the execution-FSM handshake.
- Accepts 16-bit instruction words over a valid/ready interface and decodes opcode, param1 and param2.
- Issues a one-cycle start code to the matching execution FSM (ALU, load-immediate, move), holds operands stable, then waits for that FSM's done.
- Sits between the instruction source and the execution FSMs. Only one instruction is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 32: WAIT cycles allowed without done before an instruction is abandoned.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word present
- instr_data  in  16  [15:12] opcode, [11:6] param1, [5:0] param2
- instr_ready  out  1  dispatcher can accept a word
- FSM_start  out  4  target FSM code; 4'hF = none
- opcode  out  4  latched opcode, also the ALU control
- param1  out  6  latched param1 (destination/source A)
- param2  out  6  latched param2 (source B)
- done  in  1  completion pulse from the active execution FSM
- busy  out  1  instruction in flight
- retire  out  1  one-cycle pulse when an instruction completes
- err_illegal  out  1  one-cycle pulse for an undecodable opcode
- err_timeout  out  1  one-cycle pulse when done never arrived
- retired_count  out  CNT_W  count of retired instructions, wraps

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; FSM_start=4'hF; opcode, param1, param2 = 0.
  - instr_ready=0 while reset is asserted, then 1 on the first clock in IDLE.
  - busy, retire, err_illegal, err_timeout = 0; retired_count=0; timeout counter=0.
- States IDLE, DECODE, START, WAIT. All outputs are registered.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready: latch the fields into opcode, param1, param2; go to DECODE; busy=1 next cycle.
- DECODE (1 cycle):
  - Target lookup: opcodes 0x0-0x7 -> 4'h0 (ALU); 0x8 -> 4'h1 (load-imm); 0x9 -> 4'h2 (move); 0xA-0xF illegal.
  - Legal opcode: go to START.
  - Illegal opcode: pulse err_illegal for 1 cycle, clear busy, return to IDLE. FSM_start is never driven.
- START (1 cycle):
  - FSM_start = target code for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - FSM_start=4'hF.
  - opcode, param1, param2 are held stable until the state leaves WAIT; the execution FSM samples them mid-sequence.
  - done=1: pulse retire, increment retired_count (modulo 2^CNT_W), clear busy, go to IDLE.
  - Otherwise increment the timeout counter. When the counter equals TIMEOUT_CYCLES-1 and done=0: pulse err_timeout, clear busy, go to IDLE.
  - done and the timeout boundary in the same cycle: done wins (retire, no err_timeout).
- done outside WAIT (including during START) is ignored.
- Latency:
  - Handshake accepted at edge N; FSM_start valid in cycle N+2.
  - Earliest retire: the cycle after done is sampled.
  - instr_ready returns the cycle after retire or error.
- instr_ready=0 in DECODE, START and WAIT. instr_data is not sampled then, even if instr_valid is held.
- Reset mid-operation: immediate return to IDLE.
  - FSM_start=4'hF at once (asynchronous), so no spurious start code.
  - No retire or error pulse is generated.
- retired_count wraps 0xFFFF -> 0x0000 with no flag.

Decomposition:
- Shared package dispatch_pkg:
  - State encoding.
  - FSM code constants FSM_ALU=4'h0, FSM_LDI=4'h1, FSM_MOV=4'h2, FSM_NONE=4'hF.
  - Opcode field bit positions.
  - Opcode-to-target lookup function, reused by the execution FSMs' assertions.
- One natural sub-module: dispatch_timeout_ctr.
  - Clear, enable and expire outputs, parameterised by TIMEOUT_CYCLES.
  - Everything else stays in one module.

Test Plan:
- Reset release, instr_data=16'h1845 (op 1, p1 33, p2 5), valid held 1 -> FSM_start=4'h0 for exactly 1 cycle at N+2; opcode=1, param1=33, param2=5 stable through WAIT; done after 11 cycles -> retire pulse, retired_count=1, instr_ready=1 next cycle.
- instr_data=16'hA000 (op 0xA) -> err_illegal one pulse; FSM_start stays 4'hF throughout; back in IDLE after 2 cycles; retired_count unchanged.
- ALU opcode, done never asserted, TIMEOUT_CYCLES=32 -> err_timeout pulse exactly 32 cycles into WAIT; busy=0; next instruction accepted.
- done asserted on the timeout boundary cycle -> retire=1, err_timeout=0.
- Drop reset to 0 during WAIT -> FSM_start=4'hF, busy=0, count=0 immediately with no clock edge; no pulses; a new instruction after release dispatches normally.
- Preload retired_count=16'hFFFF via 65535 quick retires (done 1 cycle after start), then one more retire -> count=16'h0000.
- Opcodes 0x8 and 0x9 -> FSM_start=4'h1 and 4'h2 respectively.
